tff_seq_ctrl: RTL and testbench
===============================

Name: tff_seq_ctrl

Overview:
- Controller that sequences a bank of WIDTH T flip-flop cells as a synchronous programmable-modulus counter.
- Every cycle it computes the per-bit toggle-enable vector, so the cell bank never needs a parallel load.
- It clears the bank by toggling its set bits, counts 0..M-1, and reports a terminal-count pulse on each wrap.
- A start/done handshake covers a programmed number of wraps; stop aborts a run. Sits between the timing/sequencing logic and the T-flip-flop datapath.

Parameters:
- WIDTH, 8, counter width and number of T flip-flop cells.
- WRAPW, 8, width of the wrap-count target and wrap counter.

Ports:
- clk  input  1  clock, all state changes on rising edge.
- rst_n  input  1  synchronous reset, active low.
- start  input  1  one-cycle run request; sampled only in IDLE.
- stop  input  1  abort request; honoured in CLEAR and RUN.
- modulus  input  WIDTH  count modulus M, latched on accepted start; 0 means 2^WIDTH.
- wrap_target  input  WRAPW  number of wraps per run, latched on accepted start; 0 means run until stop.
- count  output  WIDTH  current T-flip-flop bank value.
- t_vec  output  WIDTH  toggle enables currently driven into the bank.
- tc  output  1  high during the cycle where count==M-1 in RUN (the wrap cycle).
- busy  output  1  high in CLEAR and RUN.
- done  output  1  one-cycle pulse after a run completes normally.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous, active low. While rst_n=0 at a rising edge, all cells, latched config, wrap counter and done go to 0 and state goes to IDLE. All outputs are 0 out of reset.
- States are IDLE, CLEAR and RUN.
- IDLE: t_vec=0 and count holds. On start=1 && stop=0, latch modulus and wrap_target, clear the wrap counter, go to CLEAR. start together with stop in IDLE is ignored.
- CLEAR (exactly one cycle): t_vec=count, so count=0 after the edge. Then go to RUN; if stop=1, go to IDLE with t_vec=0.
- RUN, increment: t_vec[0]=1 and t_vec[i]=&count[i-1:0].
- RUN, wrap: when count==M_eff-1, set t_vec=count (next count 0), assert tc, and increment the wrap counter.
- M_eff = modulus, or 2^WIDTH when modulus=0. The wrap compare uses WIDTH+1-bit arithmetic; for M=2^WIDTH the natural rollover is identical.
- M=1: count stays 0 and tc is high every RUN cycle.
- Completion: if wrap_target!=0 and the wrap counter reaches target on this wrap, go to IDLE. done is registered, high for one cycle after that edge; count=0 at that point.
- The wrap counter saturates at all-ones when target=0.
- stop=1 in RUN: t_vec=0 that cycle (stop beats counting and wrap), go to IDLE with count frozen, no done, no tc.
- busy is high in CLEAR and RUN and low in IDLE, including the cycle done is high.
- Latency: start at edge k → CLEAR during cycle k+1 → count=0 and RUN at k+2 → count=1 at k+3.
- start while busy is ignored. Modulus changes after latch have no effect until the next start.
- Reset mid-run overrides everything within one edge.

Optional Feature:
- Macro TFF_DIR_EN.
- Defined: adds input up_dn (1=up), latched on start.
  - Down increment: t_vec[0]=1 and t_vec[i]=&~count[i-1:0].
  - Down wrap: occurs at count==0 with t_vec=M_eff-1 (next count M_eff-1), asserts tc and counts as a wrap.
  - CLEAR still clears to 0, so the first down step is a wrap.
- Undefined: no up_dn port; up-counting only.

Decomposition:
- Package tff_seq_pkg holds the state enum (IDLE, CLEAR, RUN) and the encoding localparams.
- Natural sub-module tff_cell: one T flip-flop with synchronous active-low reset, instantiated WIDTH times via generate. The controller drives only t_vec into the bank and reads count back.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with start=0 → count=0, t_vec=0, busy=0, done=0, tc=0.
- Basic run, WIDTH=8: M=5, target=2, start → CLEAR, count sequence 0,1,2,3,4,0,1,2,3,4,0; tc high at each count=4; done high one cycle after the second wrap; busy then 0.
- Clear from nonzero: stop at count=3, then start with M=10 → t_vec=8'h03 in CLEAR, count=0 next cycle.
- Stop priority: stop asserted in the same cycle as count==M-1 → no tc, no wrap, count frozen at M-1, IDLE, done=0.
- Edge moduli: M=1 → tc every RUN cycle; M=0, target=1 → 256 counts, wrap 255→0, done.
- Start ignored while busy, and start with stop in IDLE ignored. With TFF_DIR_EN, up_dn=0, M=6: count 0→5→4…0→5, tc at each 0.

Source files
------------

// File: rtl/tff_seq_pkg.sv
// Shared state encoding for the T-flip-flop sequence controller.
package tff_seq_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_CLEAR = 2'd1;
    localparam logic [1:0] ENC_RUN   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_CLEAR = ENC_CLEAR,
        ST_RUN   = ENC_RUN
    } state_t;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop cell with synchronous active-low reset.
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_seq_ctrl.sv
// Programmable-modulus counter built from a bank of T flip-flop cells.
// Optional down counting via macro TFF_DIR_EN (adds up_dn input).
module tff_seq_ctrl
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WRAPW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WRAPW-1:0] wrap_target,
`ifdef TFF_DIR_EN
    input  logic             up_dn,
`endif
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] t_vec,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH-1:0] cfg_mod;
    logic [WRAPW-1:0] cfg_tgt;
    logic [WRAPW-1:0] wrap_cnt;
    logic [WRAPW-1:0] wrap_nxt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH:0]   m_eff;
    logic [WIDTH:0]   m_last;
    logic [WIDTH-1:0] inc_vec;
    logic             at_wrap;
    logic             finish;

    // modulus 0 selects the full 2^WIDTH range
    assign m_eff  = (cfg_mod == '0) ? {1'b1, {WIDTH{1'b0}}}
                                    : {1'b0, cfg_mod};
    assign m_last = m_eff - 1'b1;

    always_comb begin
        logic carry;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            inc_vec[i] = carry;
            carry      = carry & count[i];
        end
    end

`ifdef TFF_DIR_EN
    logic             cfg_up;
    logic [WIDTH-1:0] dec_vec;

    always_comb begin
        logic borrow;
        borrow = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            dec_vec[i] = borrow;
            borrow     = borrow & ~count[i];
        end
    end

    assign at_wrap = cfg_up ? ({1'b0, count} == m_last)
                            : (count == '0);
`else
    assign at_wrap = ({1'b0, count} == m_last);
`endif

    assign wrap_nxt = (wrap_cnt == '1) ? wrap_cnt : wrap_cnt + 1'b1;
    assign finish   = at_wrap && (cfg_tgt != '0) && (wrap_nxt == cfg_tgt);

    always_comb begin
        t_vec = '0;
        tc    = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                if (!stop) t_vec = count;
            end
            ST_RUN: begin
                if (!stop) begin
                    tc = at_wrap;
`ifdef TFF_DIR_EN
                    if (cfg_up) begin
                        t_vec = at_wrap ? count : inc_vec;
                    end else begin
                        // count is 0 here, so toggling M-1 loads M-1
                        t_vec = at_wrap ? m_last[WIDTH-1:0] : dec_vec;
                    end
`else
                    t_vec = at_wrap ? count : inc_vec;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cfg_mod  <= '0;
            cfg_tgt  <= '0;
            wrap_cnt <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef TFF_DIR_EN
            cfg_up   <= 1'b1;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        cfg_mod  <= modulus;
                        cfg_tgt  <= wrap_target;
                        wrap_cnt <= '0;
`ifdef TFF_DIR_EN
                        cfg_up   <= up_dn;
`endif
                        busy_q   <= 1'b1;
                        state    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (stop) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (at_wrap) begin
                        wrap_cnt <= wrap_nxt;
                        if (finish) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_cell
            tff_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .t     (t_vec[g]),
                .q     (count[g])
            );
        end
    endgenerate

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Directed bench for tff_seq_ctrl with a per-cycle arithmetic reference model.
module tb_tff_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] modulus;
    logic [7:0] wrap_target;
    logic       up_dn;
    logic [7:0] count;
    logic [7:0] t_vec;
    logic       tc;
    logic       busy;
    logic       done;

    int  vecs = 0;
    int  miscompares = 0;
    bit  armed = 0;

    always #5 clk = ~clk;

    tff_seq_ctrl #(.WIDTH(8), .WRAPW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .modulus     (modulus),
        .wrap_target (wrap_target),
`ifdef TFF_DIR_EN
        .up_dn       (up_dn),
`endif
        .count       (count),
        .t_vec       (t_vec),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, exp);
        end
    endtask

    // reference model: 0=idle 1=clear 2=run
    int m_st  = 0;
    int m_cnt = 0;
    int m_mod = 256;
    int m_tgt = 0;
    int m_wr  = 0;
    bit m_done = 0;
    bit m_up = 1;

    always @(negedge clk) begin
        int nxt;
        int e_tv;
        bit e_tc;
        bit wrapc;
        nxt = 0;
        wrapc = 0;
        if (m_up) begin
            wrapc = (m_cnt == m_mod - 1);
            nxt = (m_cnt + 1) % m_mod;
        end else begin
            wrapc = (m_cnt == 0);
            nxt = (m_cnt == 0) ? m_mod - 1 : m_cnt - 1;
        end
        e_tv = 0;
        e_tc = 0;
        if (m_st == 1 && !stop) e_tv = m_cnt;
        if (m_st == 2 && !stop) begin
            e_tv = m_cnt ^ nxt;
            e_tc = wrapc;
        end
        if (armed) begin
            chk("m_count", int'(count), m_cnt);
            chk("m_t_vec", int'(t_vec), e_tv);
            chk("m_tc", int'(tc), int'(e_tc));
            chk("m_busy", int'(busy), int'(m_st != 0));
            chk("m_done", int'(done), int'(m_done));
        end
        if (!rst_n) begin
            m_st = 0; m_cnt = 0; m_mod = 256;
            m_tgt = 0; m_wr = 0; m_done = 0; m_up = 1;
        end else begin
            m_done = 0;
            case (m_st)
                0: if (start && !stop) begin
                    m_mod = (modulus == 0) ? 256 : int'(modulus);
                    m_tgt = int'(wrap_target);
                    m_wr  = 0;
`ifdef TFF_DIR_EN
                    m_up  = up_dn;
`else
                    m_up  = 1;
`endif
                    m_st  = 1;
                end
                1: if (stop) m_st = 0;
                   else begin m_cnt = 0; m_st = 2; end
                default: if (stop) m_st = 0;
                    else begin
                        m_cnt = nxt;
                        if (wrapc) begin
                            if (m_wr < 255) m_wr++;
                            if (m_tgt != 0 && m_wr == m_tgt) begin
                                m_st = 0;
                                m_done = 1;
                            end
                        end
                    end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; start = 0; stop = 0;
        modulus = 0; wrap_target = 0; up_dn = 1;
        tick();
        armed = 1;
        tick();
        chk("rst_count", int'(count), 0);
        chk("rst_t_vec", int'(t_vec), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_tc", int'(tc), 0);
        rst_n = 1;
        tick();

        // basic run M=5, two wraps
        modulus = 8'd5; wrap_target = 8'd2; start = 1;
        tick();
        start = 0;
        chk("clr_busy", int'(busy), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("basic_cnt", int'(count), i % 5);
            chk("basic_tc", int'(tc), int'(i % 5 == 4));
        end
        tick();
        chk("basic_done", int'(done), 1);
        chk("basic_busy", int'(busy), 0);
        chk("basic_end", int'(count), 0);
        tick();
        chk("done_pulse", int'(done), 0);

        // stop at count 3, then clear from nonzero
        modulus = 8'd10; wrap_target = 8'd0; start = 1;
        tick();
        start = 0;
        tick();
        repeat (3) tick();
        chk("pre_stop", int'(count), 3);
        stop = 1;
        tick();
        stop = 0;
        chk("frozen", int'(count), 3);
        chk("stop_busy", int'(busy), 0);
        start = 1;
        tick();
        start = 0;
        chk("clr_tvec", int'(t_vec), 8'h03);
        tick();
        chk("clr_zero", int'(count), 0);

        // stop in the wrap cycle beats tc and wrap
        repeat (9) tick();
        chk("at_last", int'(count), 9);
        chk("tc_last", int'(tc), 1);
        stop = 1;
        #1;
        chk("stop_tc", int'(tc), 0);
        chk("stop_tvec", int'(t_vec), 0);
        tick();
        stop = 0;
        chk("stop_cnt", int'(count), 9);
        chk("stop_done", int'(done), 0);

        // M=1: tc every run cycle
        modulus = 8'd1; wrap_target = 8'd3; start = 1;
        tick();
        start = 0;
        tick();
        chk("m1_cnt", int'(count), 0);
        chk("m1_tc", int'(tc), 1);
        repeat (3) tick();
        chk("m1_done", int'(done), 1);

        // M=0: full 256-state range, one wrap
        modulus = 8'd0; wrap_target = 8'd1; start = 1;
        tick();
        start = 0;
        tick();
        repeat (255) tick();
        chk("m0_top", int'(count), 255);
        chk("m0_tc", int'(tc), 1);
        tick();
        chk("m0_done", int'(done), 1);
        chk("m0_cnt", int'(count), 0);

        // start while busy is ignored
        modulus = 8'd4; wrap_target = 8'd0; start = 1;
        tick();
        start = 0;
        tick();
        start = 1; modulus = 8'd2;
        tick();
        start = 0;
        tick();
        chk("busy_start", int'(count), 2);
        stop = 1;
        tick();
        stop = 0;

        // start with stop in idle is ignored
        start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        chk("ss_busy", int'(busy), 0);
        tick();

        // reset mid-run
        modulus = 8'd7; start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("mid_rst_cnt", int'(count), 0);
        chk("mid_rst_busy", int'(busy), 0);
        tick();

`ifdef TFF_DIR_EN
        // down counting M=6, first step wraps
        modulus = 8'd6; wrap_target = 8'd2; up_dn = 0; start = 1;
        tick();
        start = 0;
        tick();
        chk("dn_tc0", int'(tc), 1);
        tick();
        chk("dn_5", int'(count), 5);
        tick();
        chk("dn_4", int'(count), 4);
        repeat (4) tick();
        chk("dn_0", int'(count), 0);
        chk("dn_tc", int'(tc), 1);
        tick();
        chk("dn_done", int'(done), 1);
        up_dn = 1;
        tick();
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, miscompares);
        $finish;
    end

endmodule
